// File: rtl/bp_be_int_wb_pipe.sv
// bp_be_int_wb_pipe: integer result writeback shift pipeline.
// Carries integer results to the commit point, applies flushes,
// drives the register-file write port and the operand bypass.
//
// Ports:
//   clk_i, reset_i            clock, async active-high reset
//   v_i, data_i               result valid / data from int pipe
//   rd_w_v_i, rd_addr_i       writes-rd flag / destination reg
//   flush_i                   kill uncommitted stages + input
//   rs_addr_i                 bypass lookup address
//   bypass_v_o, bypass_data_o youngest pending write to rs
//   wb_v_o, wb_addr_o,
//   wb_data_o                 register-file write port
//   retire_v_o                valid entry leaving last stage
//   retire_cnt_o              retire counter (optional)
//
// Optional: define BP_BE_INT_WB_PERF_EN to add retire_cnt_o,
// a 32-bit wrapping count of retired entries.

package bp_be_int_wb_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    function automatic int dpath_width(bp_params_e cfg);
        int w;
        case (cfg)
            e_bp_default_cfg: w = 64;
            default:          w = 64;
        endcase
        return w;
    endfunction

endpackage

module bp_be_int_wb_pipe
    import bp_be_int_wb_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int stages_p = 3,
    parameter int commit_stage_p = 2,
    localparam int dpath_width_p = dpath_width(bp_params_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [dpath_width_p-1:0] data_i,
    input  logic                     rd_w_v_i,
    input  logic [4:0]               rd_addr_i,
    input  logic                     flush_i,
    input  logic [4:0]               rs_addr_i,
    output logic                     bypass_v_o,
    output logic [dpath_width_p-1:0] bypass_data_o,
    output logic                     wb_v_o,
    output logic [4:0]               wb_addr_o,
    output logic [dpath_width_p-1:0] wb_data_o,
    output logic                     retire_v_o
`ifdef BP_BE_INT_WB_PERF_EN
    ,
    output logic [31:0]              retire_cnt_o
`endif
);

    localparam int last_lp = stages_p - 1;

    typedef struct packed {
        logic                     v;
        logic                     w_v;
        logic [4:0]               addr;
        logic [dpath_width_p-1:0] data;
    } stage_t;

    stage_t r_stage [stages_p];

    // w_kill[k]: the entry now in stage k dies on its way
    // to stage k+1 because it has not reached commit yet.
    logic [stages_p-1:0] w_kill;

    always_comb begin
        w_kill = '0;
        for (int k = 0; k < stages_p; k++) begin
            w_kill[k] = flush_i && (k < commit_stage_p);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < stages_p; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0].v    <= v_i & ~flush_i;
            // x0 is never a real destination.
            r_stage[0].w_v  <= rd_w_v_i & (rd_addr_i != 5'd0);
            r_stage[0].addr <= rd_addr_i;
            r_stage[0].data <= data_i;
            for (int k = 1; k < stages_p; k++) begin
                r_stage[k].v    <= r_stage[k-1].v & ~w_kill[k-1];
                r_stage[k].w_v  <= r_stage[k-1].w_v;
                r_stage[k].addr <= r_stage[k-1].addr;
                r_stage[k].data <= r_stage[k-1].data;
            end
        end
    end

    // Bypass over registered stages only.
    logic [stages_p-1:0]      w_match;
    logic                     w_byp_v;
    logic [dpath_width_p-1:0] w_byp_data;

    always_comb begin
        w_match = '0;
        for (int k = 0; k < stages_p; k++) begin
            w_match[k] = r_stage[k].v
                       & r_stage[k].w_v
                       & (r_stage[k].addr == rs_addr_i)
                       & (rs_addr_i != 5'd0);
        end
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        w_byp_v    = 1'b0;
        w_byp_data = '0;
        for (int k = stages_p - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_byp_v    = 1'b1;
                w_byp_data = r_stage[k].data;
            end
        end
    end

    assign bypass_v_o    = w_byp_v;
    assign bypass_data_o = w_byp_data;

    logic w_wb_v;

    assign w_wb_v     = r_stage[last_lp].v & r_stage[last_lp].w_v;
    assign wb_v_o     = w_wb_v;
    assign wb_addr_o  = w_wb_v ? r_stage[last_lp].addr : 5'd0;
    assign wb_data_o  = w_wb_v ? r_stage[last_lp].data : '0;
    assign retire_v_o = r_stage[last_lp].v;

`ifdef BP_BE_INT_WB_PERF_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_retire_cnt <= 32'd0;
        end else if (r_stage[last_lp].v) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt_o = r_retire_cnt;
`endif

endmodule

// File: tb/tb_bp_be_int_wb_pipe.sv
// tb_bp_be_int_wb_pipe: directed + random bench for the
// integer writeback pipe, checked against a timestamp model.

module tb_bp_be_int_wb_pipe;

    localparam int S = 3;
    localparam int C = 2;
    localparam int W = 64;
    localparam int N = 8192;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         rd_w_v_i;
    logic [4:0]   rd_addr_i;
    logic         flush_i;
    logic [4:0]   rs_addr_i;
    logic         bypass_v_o;
    logic [W-1:0] bypass_data_o;
    logic         wb_v_o;
    logic [4:0]   wb_addr_o;
    logic [W-1:0] wb_data_o;
    logic         retire_v_o;
`ifdef BP_BE_INT_WB_PERF_EN
    logic [31:0]  retire_cnt_o;
`endif

    bp_be_int_wb_pipe #(
        .stages_p       (S),
        .commit_stage_p (C)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .data_i        (data_i),
        .rd_w_v_i      (rd_w_v_i),
        .rd_addr_i     (rd_addr_i),
        .flush_i       (flush_i),
        .rs_addr_i     (rs_addr_i),
        .bypass_v_o    (bypass_v_o),
        .bypass_data_o (bypass_data_o),
        .wb_v_o        (wb_v_o),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .retire_v_o    (retire_v_o)
`ifdef BP_BE_INT_WB_PERF_EN
        ,
        .retire_cnt_o  (retire_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: one record per cycle, indexed by the cycle the
    // result was presented. An entry from cycle t retires in
    // cycle t+S unless killed; a flush in cycle c kills every
    // entry with c-t <= C, a reset kills everything in flight.
    bit           acc_v [N];
    bit           acc_w [N];
    bit           dead  [N];
    logic [4:0]   acc_a [N];
    logic [W-1:0] acc_d [N];
    logic [31:0]  m_cnt = 32'd0;

    task automatic chk(string nm, logic [W-1:0] act,
                       logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int           t;
        bit           e_ret;
        bit           e_wb;
        bit           e_bv;
        logic [4:0]   e_a;
        logic [W-1:0] e_d;
        logic [W-1:0] e_bd;
        e_ret = 1'b0;
        e_wb  = 1'b0;
        e_bv  = 1'b0;
        e_a   = 5'd0;
        e_d   = '0;
        e_bd  = '0;
        if (reset_i) begin
            m_cnt = 32'd0;
        end else begin
            t = cyc - S;
            if (t >= 0 && acc_v[t] && !dead[t]) begin
                e_ret = 1'b1;
                if (acc_w[t]) begin
                    e_wb = 1'b1;
                    e_a  = acc_a[t];
                    e_d  = acc_d[t];
                end
            end
            for (int u = cyc - 1; u >= cyc - S; u--) begin
                if (u >= 0 && !e_bv && acc_v[u] && !dead[u]
                    && acc_w[u] && acc_a[u] == rs_addr_i) begin
                    e_bv = 1'b1;
                    e_bd = acc_d[u];
                end
            end
        end
        chk("m_wb_v",   W'(wb_v_o),        W'(e_wb));
        chk("m_wb_addr", W'(wb_addr_o),    W'(e_a));
        chk("m_wb_data", wb_data_o,        e_d);
        chk("m_retire", W'(retire_v_o),    W'(e_ret));
        chk("m_byp_v",  W'(bypass_v_o),    W'(e_bv));
        chk("m_byp_data", bypass_data_o,   e_bd);
`ifdef BP_BE_INT_WB_PERF_EN
        chk("m_cnt", W'(retire_cnt_o), W'(m_cnt));
`endif
        if (e_ret) m_cnt = m_cnt + 32'd1;
        if (cyc < N) begin
            acc_v[cyc] = !reset_i && v_i;
            acc_w[cyc] = rd_w_v_i && (rd_addr_i != 5'd0);
            acc_a[cyc] = rd_addr_i;
            acc_d[cyc] = data_i;
            dead[cyc]  = 1'b0;
            if (reset_i) begin
                for (int k = 0; k <= S; k++)
                    if (cyc - k >= 0) dead[cyc-k] = 1'b1;
            end else if (flush_i) begin
                for (int k = 0; k <= C; k++)
                    if (cyc - k >= 0) dead[cyc-k] = 1'b1;
            end
        end
        cyc++;
    end

    task automatic drive(bit v, bit w, logic [4:0] a,
                         logic [W-1:0] d, bit f,
                         logic [4:0] rs);
        v_i       = v;
        rd_w_v_i  = w;
        rd_addr_i = a;
        data_i    = d;
        flush_i   = f;
        rs_addr_i = rs;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef BP_BE_INT_WB_PERF_EN
        logic [31:0] c0;
`endif
        reset_i = 1'b1;
        drive(0, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("rst_wb_v",   W'(wb_v_o),     0);
        chk("rst_retire", W'(retire_v_o), 0);
        chk("rst_byp_v",  W'(bypass_v_o), 0);
        next();
        next();
        reset_i = 1'b0;
        next();

        // Latency
        drive(1, 1, 5'd5, 64'h1234, 0, 0);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            next();
            drive(0, 0, 0, '0, 0, 0);
            @(negedge clk);
            if (i == 3) begin
                chk("lat_wb_v",   W'(wb_v_o),     1);
                chk("lat_addr",   W'(wb_addr_o),  5);
                chk("lat_data",   wb_data_o,      64'h1234);
                chk("lat_retire", W'(retire_v_o), 1);
            end else begin
                chk("lat_idle_wb_v", W'(wb_v_o), 0);
            end
        end

        // Back-to-back bypass
        for (int i = 0; i <= 5; i++) begin
            next();
            drive(i < 2, 1, 5'd7, (i == 0) ? 64'hA : 64'hB,
                  0, 5'd7);
            @(negedge clk);
            if (i >= 2 && i <= 4) begin
                chk("byp_v",    W'(bypass_v_o), 1);
                chk("byp_data", bypass_data_o,  64'hB);
            end else if (i == 5) begin
                chk("byp_gone_v", W'(bypass_v_o), 0);
            end
        end

        // Flush boundary: x3 reaches stage 2 as x4 + flush
        for (int i = 0; i <= 6; i++) begin
            next();
            if (i < 3)
                drive(1, 1, 5'(3 - i), 64'(32'h30 + i), 0, 0);
            else if (i == 3)
                drive(1, 1, 5'd4, 64'h44, 1, 0);
            else
                drive(0, 0, 0, '0, 0, 0);
            @(negedge clk);
            if (i == 3) begin
                chk("fl_wb_v",   W'(wb_v_o),     1);
                chk("fl_addr",   W'(wb_addr_o),  3);
                chk("fl_retire", W'(retire_v_o), 1);
`ifdef BP_BE_INT_WB_PERF_EN
                c0 = retire_cnt_o;
`endif
            end else if (i > 3) begin
                chk("fl_kill_wb_v",   W'(wb_v_o),     0);
                chk("fl_kill_retire", W'(retire_v_o), 0);
            end
        end
`ifdef BP_BE_INT_WB_PERF_EN
        chk("fl_cnt", W'(retire_cnt_o), W'(c0 + 32'd1));
`endif

        // x0 destination, then a non-writing instruction
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i <= 3; i++) begin
                next();
                if (i == 0 && j == 0)
                    drive(1, 1, 5'd0, 64'hFFFF, 0, 0);
                else if (i == 0)
                    drive(1, 0, 5'd9, 64'h99, 0, 5'd9);
                else
                    drive(0, 0, 0, '0, 0,
                          (j == 0) ? 5'd0 : 5'd9);
                @(negedge clk);
                if (i == 1 || i == 2) begin
                    chk("x0_byp_v", W'(bypass_v_o), 0);
                end else if (i == 3) begin
                    chk("x0_retire", W'(retire_v_o), 1);
                    chk("x0_wb_v",   W'(wb_v_o),     0);
                end
            end
        end

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            next();
            drive(1, 1, 5'(10 + i), 64'(32'hC0 + i), 0, 5'd11);
            @(negedge clk);
        end
        next();
        drive(0, 0, 0, '0, 0, 5'd11);
        #3;
        reset_i = 1'b1;
        #1;
        chk("mrst_wb_v",   W'(wb_v_o),      0);
        chk("mrst_addr",   W'(wb_addr_o),   0);
        chk("mrst_data",   wb_data_o,       0);
        chk("mrst_retire", W'(retire_v_o),  0);
        chk("mrst_byp_v",  W'(bypass_v_o),  0);
        chk("mrst_byp_d",  bypass_data_o,   0);
        next();
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mrst_after_wb_v",   W'(wb_v_o),     0);
            chk("mrst_after_retire", W'(retire_v_o), 0);
            next();
        end

`ifdef BP_BE_INT_WB_PERF_EN
        // Counter wrap
        #1;
        dut.r_retire_cnt = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int i = 0; i <= 6; i++) begin
            next();
            drive(i < 3, 1, 5'd20, 64'(i), 0, 0);
            @(negedge clk);
            if (i == 4) chk("wrap_ff", W'(retire_cnt_o),
                            64'hFFFF_FFFF);
            if (i == 5) chk("wrap_0", W'(retire_cnt_o), 0);
            if (i == 6) chk("wrap_1", W'(retire_cnt_o), 1);
        end
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            next();
            reset_i = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)),
                  {$urandom, $urandom},
                  $urandom_range(0, 7) == 0,
                  5'($urandom_range(0, 7)));
            @(negedge clk);
        end
        next();
        reset_i = 1'b0;
        drive(0, 0, 0, '0, 0, 0);
        repeat (S + 2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
